sq_operand_sequencer: RTL and testbench

//  Sequenced, parametrised partial-product operand scheduler for the chunked squarer/multiplier.

---
 rtl/sq_operand_sequencer_if.sv | 29 ++
 rtl/sq_operand_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sq_operand_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sq_operand_sequencer_if.sv
// Partial-product beat stream from the operand sequencer to the multiplier array.
// master = sequencer (drives beats), slave = multiplier array (drives pp_ready).
interface sq_operand_sequencer_if #(
  parameter int LANES = 33,
  parameter int A_W   = 25,
  parameter int B_W   = 18,
  parameter int IW    = 2,
  parameter int SW    = 3
);
  logic                 pp_valid;
  logic                 pp_ready;
  logic [LANES*A_W-1:0] pp_a;
  logic [LANES*B_W-1:0] pp_b;
  logic [IW-1:0]        pp_i;
  logic [IW-1:0]        pp_j;
  logic [SW-1:0]        pp_wt;
  logic                 pp_dbl;
  logic                 pp_last;

  modport master (
    output pp_valid, pp_a, pp_b, pp_i, pp_j, pp_wt, pp_dbl, pp_last,
    input  pp_ready
  );

  modport slave (
    input  pp_valid, pp_a, pp_b, pp_i, pp_j, pp_wt, pp_dbl, pp_last,
    output pp_ready
  );
endinterface

// File: rtl/sq_operand_sequencer.sv
// Walks every chunk pair (i,j) of a captured operand in descending weight order and
// streams lane-aligned, zero-padded A/B digit vectors to the multiplier array.
//
// state  | meaning
// S_IDLE | no schedule running; start accepted, pp_* held at zero
// S_RUN  | a beat is presented on pp_*; advance on handshake, leave on last beat or abort
module sq_operand_sequencer #(
  parameter int NCHUNK       = 4,
  parameter int CHUNK_DIGITS = 32,
  parameter int DIGIT_W      = 17,
  parameter int A_W          = 25,
  parameter int B_W          = 18
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  output logic                                       start_rdy,
  input  logic                                       mode_mul,
  input  logic [(NCHUNK*CHUNK_DIGITS+1)*DIGIT_W-1:0] op_a,
  input  logic [(NCHUNK*CHUNK_DIGITS+1)*DIGIT_W-1:0] op_b,
  input  logic                                       abort,
  output logic                                       done,
  sq_operand_sequencer_if.master                     pp
);

  localparam int NDIG  = NCHUNK*CHUNK_DIGITS + 1;
  localparam int LANES = CHUNK_DIGITS + 1;
  localparam int IW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SW    = (NCHUNK > 1) ? $clog2(2*NCHUNK-1) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             s_q, s_d;
  logic [IW-1:0]             i_q, i_d, j_d;
  logic                      mul_q, use_mul;
  logic [NDIG*DIGIT_W-1:0]   cap_a, cap_b, src_a, src_b;
  logic [LANES*A_W-1:0]      beat_a;
  logic [LANES*B_W-1:0]      beat_b;
  logic                      load, clear, done_d;
  int                        lo;

  // The top chunk also carries the single extra digit NDIG-1 in its top lane.
  function automatic logic [LANES*A_W-1:0] build_a(input logic [NDIG*DIGIT_W-1:0] src, input int idx);
    logic [LANES*A_W-1:0] v;
    v = '0;
    for (int l = 0; l < CHUNK_DIGITS; l++)
      v[l*A_W +: A_W] = A_W'(src[(idx*CHUNK_DIGITS+l)*DIGIT_W +: DIGIT_W]);
    if (idx == NCHUNK-1)
      v[CHUNK_DIGITS*A_W +: A_W] = A_W'(src[(NDIG-1)*DIGIT_W +: DIGIT_W]);
    return v;
  endfunction

  function automatic logic [LANES*B_W-1:0] build_b(input logic [NDIG*DIGIT_W-1:0] src, input int idx);
    logic [LANES*B_W-1:0] v;
    v = '0;
    for (int l = 0; l < CHUNK_DIGITS; l++)
      v[l*B_W +: B_W] = B_W'(src[(idx*CHUNK_DIGITS+l)*DIGIT_W +: DIGIT_W]);
    if (idx == NCHUNK-1)
      v[CHUNK_DIGITS*B_W +: B_W] = B_W'(src[(NDIG-1)*DIGIT_W +: DIGIT_W]);
    return v;
  endfunction

  assign start_rdy = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    i_d     = i_q;
    load    = 1'b0;
    clear   = 1'b0;
    done_d  = 1'b0;
    lo      = 0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = SW'(2*(NCHUNK-1));
          i_d     = IW'(NCHUNK-1);
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end else if (pp.pp_valid && pp.pp_ready) begin
          if (pp.pp_last) begin
            state_d = S_IDLE;
            clear   = 1'b1;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            // Square mode skips mirrored pairs (i<j); the consumer doubles instead.
            if (mul_q) lo = (int'(s_q) > NCHUNK-1) ? int'(s_q) - NCHUNK + 1 : 0;
            else       lo = (int'(s_q) + 1) / 2;
            if (int'(i_q) > lo) begin
              i_d = i_q - IW'(1);
            end else begin
              s_d = s_q - SW'(1);
              i_d = (int'(s_q) - 1 > NCHUNK-1) ? IW'(NCHUNK-1) : IW'(int'(s_q) - 1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // On the start cycle the first beat is built straight from the input operands.
  always_comb begin
    use_mul = (state_q == S_IDLE) ? mode_mul : mul_q;
    src_a   = (state_q == S_IDLE) ? op_a : cap_a;
    src_b   = use_mul ? ((state_q == S_IDLE) ? op_b : cap_b) : src_a;
    j_d     = IW'(int'(s_d) - int'(i_d));
    beat_a  = build_a(src_a, int'(i_d));
    beat_b  = build_b(src_b, int'(j_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_a       <= '0;
      cap_b       <= '0;
      mul_q       <= 1'b0;
      s_q         <= '0;
      i_q         <= '0;
      done        <= 1'b0;
      pp.pp_valid <= 1'b0;
      pp.pp_a     <= '0;
      pp.pp_b     <= '0;
      pp.pp_i     <= '0;
      pp.pp_j     <= '0;
      pp.pp_wt    <= '0;
      pp.pp_dbl   <= 1'b0;
      pp.pp_last  <= 1'b0;
    end else begin
      s_q  <= s_d;
      i_q  <= i_d;
      done <= done_d;
      if (state_q == S_IDLE && start) begin
        cap_a <= op_a;
        cap_b <= op_b;
        mul_q <= mode_mul;
      end
      if (load) begin
        pp.pp_valid <= 1'b1;
        pp.pp_a     <= beat_a;
        pp.pp_b     <= beat_b;
        pp.pp_i     <= i_d;
        pp.pp_j     <= j_d;
        pp.pp_wt    <= s_d;
        pp.pp_dbl   <= !use_mul && (i_d != j_d);
        pp.pp_last  <= (s_d == '0);
      end else if (clear) begin
        pp.pp_valid <= 1'b0;
        pp.pp_a     <= '0;
        pp.pp_b     <= '0;
        pp.pp_i     <= '0;
        pp.pp_j     <= '0;
        pp.pp_wt    <= '0;
        pp.pp_dbl   <= 1'b0;
        pp.pp_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sq_operand_sequencer.sv
// Directed bench for sq_operand_sequencer: NCHUNK=4 schedules from a beat table plus
// hand-written abort/reset/stall sequences, and an NCHUNK=1 single-beat instance.
module tb_sq_operand_sequencer;
  localparam int DW = 17;
  localparam int AW = 25;
  localparam int BW = 18;
  localparam int NDIG4 = 129;
  localparam int NDIG1 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  start4, start_rdy4, mode4, abort4, done4;
  logic [NDIG4*DW-1:0]   opa4, opb4;
  logic                  start1, start_rdy1, mode1, abort1, done1;
  logic [NDIG1*DW-1:0]   opa1, opb1;

  sq_operand_sequencer_if #(.LANES(33), .A_W(AW), .B_W(BW), .IW(2), .SW(3)) pp4 ();
  sq_operand_sequencer_if #(.LANES(5),  .A_W(AW), .B_W(BW), .IW(1), .SW(1)) pp1 ();

  sq_operand_sequencer #(.NCHUNK(4), .CHUNK_DIGITS(32), .DIGIT_W(DW), .A_W(AW), .B_W(BW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .start_rdy(start_rdy4), .mode_mul(mode4),
    .op_a(opa4), .op_b(opb4), .abort(abort4), .done(done4), .pp(pp4)
  );

  sq_operand_sequencer #(.NCHUNK(1), .CHUNK_DIGITS(4), .DIGIT_W(DW), .A_W(AW), .B_W(BW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .start_rdy(start_rdy1), .mode_mul(mode1),
    .op_a(opa1), .op_b(opb1), .abort(abort1), .done(done1), .pp(pp1)
  );

  typedef struct {
    bit mul;
    int i;
    int j;
    int wt;
    bit dbl;
    bit last;
  } vec_t;

  vec_t vt [26];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Operand pattern: A digit k = k+1, B digit k = 1000+k, so lane values follow from (i,j).
  task automatic check_beat(input int v);
    int ea0, ea32, eb0, eb32;
    ea0  = 32*vt[v].i + 1;
    ea32 = (vt[v].i == 3) ? 129 : 0;
    if (vt[v].mul) begin
      eb0  = 1000 + 32*vt[v].j;
      eb32 = (vt[v].j == 3) ? 1128 : 0;
    end else begin
      eb0  = 32*vt[v].j + 1;
      eb32 = (vt[v].j == 3) ? 129 : 0;
    end
    chk($sformatf("v%0d valid", v), 64'(pp4.pp_valid), 1);
    chk($sformatf("v%0d i", v),     64'(pp4.pp_i), 64'(vt[v].i));
    chk($sformatf("v%0d j", v),     64'(pp4.pp_j), 64'(vt[v].j));
    chk($sformatf("v%0d wt", v),    64'(pp4.pp_wt), 64'(vt[v].wt));
    chk($sformatf("v%0d dbl", v),   64'(pp4.pp_dbl), 64'(vt[v].dbl));
    chk($sformatf("v%0d last", v),  64'(pp4.pp_last), 64'(vt[v].last));
    chk($sformatf("v%0d done", v),  64'(done4), 0);
    chk($sformatf("v%0d a0", v),    64'(pp4.pp_a[0 +: AW]), 64'(ea0));
    chk($sformatf("v%0d a31", v),   64'(pp4.pp_a[31*AW +: AW]), 64'(ea0 + 31));
    chk($sformatf("v%0d a32", v),   64'(pp4.pp_a[32*AW +: AW]), 64'(ea32));
    chk($sformatf("v%0d b0", v),    64'(pp4.pp_b[0 +: BW]), 64'(eb0));
    chk($sformatf("v%0d b31", v),   64'(pp4.pp_b[31*BW +: BW]), 64'(eb0 + 31));
    chk($sformatf("v%0d b32", v),   64'(pp4.pp_b[32*BW +: BW]), 64'(eb32));
  endtask

  // Start a schedule, then scramble the inputs to prove they were captured.
  task automatic start_beat(input bit mul);
    for (int k = 0; k < NDIG4; k++) begin
      opa4[k*DW +: DW] = DW'(k + 1);
      opb4[k*DW +: DW] = DW'(1000 + k);
    end
    mode4  = mul;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    opa4   = '1;
    opb4   = '0;
    mode4  = ~mul;
  endtask

  task automatic run_sched(input bit mul, input bit rnd);
    int base, nb, b, cyc;
    bit r;
    base = mul ? 10 : 0;
    nb   = mul ? 16 : 10;
    start_beat(mul);
    b   = 0;
    cyc = 0;
    while (b < nb) begin
      if (cyc > 200) begin
        chk("beat_timeout", 64'(b), 64'(nb));
        break;
      end
      cyc++;
      check_beat(base + b);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pp4.pp_ready = r;
      @(negedge clk);
      if (r) b++;
    end
    chk("done_pulse", 64'(done4), 1);
    chk("valid_after", 64'(pp4.pp_valid), 0);
    chk("rdy_after", 64'(start_rdy4), 1);
    pp4.pp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 3, 3, 6, 0, 0};
    vt[1]  = '{0, 3, 2, 5, 1, 0};
    vt[2]  = '{0, 3, 1, 4, 1, 0};
    vt[3]  = '{0, 2, 2, 4, 0, 0};
    vt[4]  = '{0, 3, 0, 3, 1, 0};
    vt[5]  = '{0, 2, 1, 3, 1, 0};
    vt[6]  = '{0, 2, 0, 2, 1, 0};
    vt[7]  = '{0, 1, 1, 2, 0, 0};
    vt[8]  = '{0, 1, 0, 1, 1, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 1};
    vt[10] = '{1, 3, 3, 6, 0, 0};
    vt[11] = '{1, 3, 2, 5, 0, 0};
    vt[12] = '{1, 2, 3, 5, 0, 0};
    vt[13] = '{1, 3, 1, 4, 0, 0};
    vt[14] = '{1, 2, 2, 4, 0, 0};
    vt[15] = '{1, 1, 3, 4, 0, 0};
    vt[16] = '{1, 3, 0, 3, 0, 0};
    vt[17] = '{1, 2, 1, 3, 0, 0};
    vt[18] = '{1, 1, 2, 3, 0, 0};
    vt[19] = '{1, 0, 3, 3, 0, 0};
    vt[20] = '{1, 2, 0, 2, 0, 0};
    vt[21] = '{1, 1, 1, 2, 0, 0};
    vt[22] = '{1, 0, 2, 2, 0, 0};
    vt[23] = '{1, 1, 0, 1, 0, 0};
    vt[24] = '{1, 0, 1, 1, 0, 0};
    vt[25] = '{1, 0, 0, 0, 0, 1};

    rst = 1'b1;
    start4 = 1'b0; mode4 = 1'b0; abort4 = 1'b0; opa4 = '0; opb4 = '0;
    start1 = 1'b0; mode1 = 1'b0; abort1 = 1'b0; opa1 = '0; opb1 = '0;
    pp4.pp_ready = 1'b0;
    pp1.pp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst start_rdy", 64'(start_rdy4), 1);
    chk("rst valid", 64'(pp4.pp_valid), 0);
    chk("rst done", 64'(done4), 0);
    chk("rst pp_a_nz", 64'(|pp4.pp_a), 0);
    chk("rst last", 64'(pp4.pp_last), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-rate square, then multiply started in the done cycle.
    run_sched(1'b0, 1'b0);
    run_sched(1'b1, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done4), 0);

    // Random back-pressure.
    run_sched(1'b0, 1'b1);
    run_sched(1'b1, 1'b1);
    @(negedge clk);

    // Abort while idle has no effect.
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("idle_abort rdy", 64'(start_rdy4), 1);
    chk("idle_abort valid", 64'(pp4.pp_valid), 0);

    // Abort at beat 4, coinciding with a handshake.
    pp4.pp_ready = 1'b1;
    start_beat(1'b0);
    for (int b = 0; b < 4; b++) @(negedge clk);
    check_beat(4);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("abort valid", 64'(pp4.pp_valid), 0);
    chk("abort rdy", 64'(start_rdy4), 1);
    chk("abort done", 64'(done4), 0);
    chk("abort pp_i", 64'(pp4.pp_i), 0);
    @(negedge clk);
    chk("abort done2", 64'(done4), 0);

    // Abort and start together in idle: start wins and restarts at (3,3).
    abort4 = 1'b1;
    start_beat(1'b0);
    abort4 = 1'b0;
    check_beat(0);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int b = 1; b < 6; b++) begin
      check_beat(b);
      @(negedge clk);
    end
    check_beat(6);

    // Reset mid-schedule.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst valid", 64'(pp4.pp_valid), 0);
    chk("midrst rdy", 64'(start_rdy4), 1);
    chk("midrst pp_a_nz", 64'(|pp4.pp_a), 0);
    chk("midrst pp_i", 64'(pp4.pp_i), 0);
    chk("midrst wt", 64'(pp4.pp_wt), 0);
    chk("midrst dbl", 64'(pp4.pp_dbl), 0);
    chk("midrst done", 64'(done4), 0);
    pp4.pp_ready = 1'b0;

    // NCHUNK=1: a single (0,0) beat carrying all five digits.
    for (int k = 0; k < NDIG1; k++) opa1[k*DW +: DW] = DW'(50 + k);
    opb1   = '0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    opa1   = '1;
    chk("n1 valid", 64'(pp1.pp_valid), 1);
    chk("n1 i", 64'(pp1.pp_i), 0);
    chk("n1 j", 64'(pp1.pp_j), 0);
    chk("n1 wt", 64'(pp1.pp_wt), 0);
    chk("n1 dbl", 64'(pp1.pp_dbl), 0);
    chk("n1 last", 64'(pp1.pp_last), 1);
    for (int l = 0; l < NDIG1; l++) begin
      chk($sformatf("n1 a%0d", l), 64'(pp1.pp_a[l*AW +: AW]), 64'(50 + l));
      chk($sformatf("n1 b%0d", l), 64'(pp1.pp_b[l*BW +: BW]), 64'(50 + l));
    end
    @(negedge clk);
    chk("n1 stall valid", 64'(pp1.pp_valid), 1);
    chk("n1 stall a4", 64'(pp1.pp_a[4*AW +: AW]), 54);
    chk("n1 stall done", 64'(done1), 0);
    pp1.pp_ready = 1'b1;
    @(negedge clk);
    pp1.pp_ready = 1'b0;
    chk("n1 done", 64'(done1), 1);
    chk("n1 valid_after", 64'(pp1.pp_valid), 0);
    @(negedge clk);
    chk("n1 done_end", 64'(done1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
